// File: rtl/kernel_loader.sv
`default_nettype none
// ============================================================================
// Module      : kernel_loader
// Description : Fetches N_COEF kernel coefficients from mem_kernel into a local
//               register bank and serves them by index.
// Revision    : 1.0
// ============================================================================
module kernel_loader #(
    parameter  int SIZE   = 16,
    parameter  int N_COEF = 9,
    parameter  int STRIDE = 4,
    localparam int SEL_W  = $clog2(N_COEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SIZE-1:0]          base,
    output logic [SIZE-1:0]          mem_addr,
    input  logic [SIZE-1:0]          mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    input  logic [SEL_W-1:0]         coef_sel,
    output logic [SIZE-1:0]          coef,
    output logic [N_COEF*SIZE-1:0]   coef_all
);

    localparam int CW = $clog2(N_COEF + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [CW-1:0] c_last_idx  = CW'(N_COEF - 1);
    localparam logic [CW-1:0] c_first_cap = CW'(2);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CW-1:0]    r_issue_cnt;
    logic [CW-1:0]    r_cap_cnt;
    logic [SIZE-1:0]  r_bank [N_COEF];
    logic             w_accept;
    logic             w_capture;
    logic             w_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (start) w_next_state = c_st_issue;
            c_st_issue: if (r_issue_cnt == c_last_idx) w_next_state = c_st_drain;
            c_st_drain: if (r_cap_cnt == c_last_idx) w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // Read data trails the address by two edges, so capture begins once the
    // second address is on the bus and continues through DRAIN.
    always_comb begin
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            c_st_idle:  w_accept  = start;
            c_st_issue: w_capture = (r_issue_cnt >= c_first_cap);
            c_st_drain: begin
                w_capture = 1'b1;
                w_last    = (r_cap_cnt == c_last_idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            valid       <= 1'b0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            for (int i = 0; i < N_COEF; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                mem_addr    <= base;
                r_issue_cnt <= CW'(1);
                r_cap_cnt   <= '0;
                valid       <= 1'b0;
                busy        <= 1'b1;
            end
            if (r_state == c_st_issue) begin
                mem_addr    <= mem_addr + SIZE'(STRIDE);
                r_issue_cnt <= r_issue_cnt + CW'(1);
            end
            if (w_capture) begin
                for (int i = 0; i < N_COEF; i++) begin
                    if (r_cap_cnt == CW'(i)) r_bank[i] <= mem_data;
                end
                r_cap_cnt <= r_cap_cnt + CW'(1);
            end
            if (w_last) begin
                done  <= 1'b1;
                valid <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end

    // Out-of-range indices fall through to zero.
    always_comb begin
        coef = '0;
        for (int i = 0; i < N_COEF; i++) begin
            if (coef_sel == SEL_W'(i)) coef = r_bank[i];
        end
    end

    generate
        for (genvar g = 0; g < N_COEF; g++) begin : g_flat
            assign coef_all[g*SIZE +: SIZE] = r_bank[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kernel_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_loader
// Description : Randomised self-checking bench for kernel_loader.
// Revision    : 1.0
// ============================================================================
module tb_kernel_loader;

    localparam int SIZE = 16;
    localparam int N    = 9;
    localparam int STR  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [SIZE-1:0]     base;
    logic [SIZE-1:0]     mem_addr;
    logic [SIZE-1:0]     mem_data;
    logic                busy;
    logic                done;
    logic                valid;
    logic [3:0]          coef_sel;
    logic [SIZE-1:0]     coef;
    logic [N*SIZE-1:0]   coef_all;

    int n_cmp = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    kernel_loader #(.SIZE(SIZE), .N_COEF(N), .STRIDE(STR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .coef_sel (coef_sel),
        .coef     (coef),
        .coef_all (coef_all)
    );

    // Memory contents: word at address 4i is 16'h0100 + i.
    function automatic logic [SIZE-1:0] word(input logic [SIZE-1:0] a);
        return 16'h0100 + {2'b00, a[SIZE-1:2]};
    endfunction

    always @(posedge clk) mem_data <= word(mem_addr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sweeps every index (including out-of-range) against the kernel at b.
    task automatic check_bank(input logic [SIZE-1:0] b, input string tag);
        logic [N*SIZE-1:0] exp_all;
        logic [SIZE-1:0]   e;
        for (int i = 0; i < N; i++) exp_all[i*SIZE +: SIZE] = word(b + 16'(i * STR));
        n_cmp++;
        if (coef_all !== exp_all) begin
            n_err++;
            $display("FAIL %s coef_all: got %h expected %h", tag, coef_all, exp_all);
        end
        for (int s = 0; s < 16; s++) begin
            coef_sel = 4'(s);
            #1;
            e = (s < N) ? exp_all[s*SIZE +: SIZE] : 16'h0000;
            n_cmp++;
            if (coef !== e) begin
                n_err++;
                $display("FAIL %s coef[%0d]: got %h expected %h", tag, s, coef, e);
            end
        end
    endtask

    // One load, edge by edge; E0 is the first edge after entry.
    task automatic run_load(input logic [SIZE-1:0] b, input bit started, input bit lockout,
                            input bit chain, input logic [SIZE-1:0] nb);
        logic [SIZE-1:0] ea;
        logic [3:0]      sel;
        if (!started) begin
            base  = b;
            start = 1'b1;
        end
        sel      = 4'hF;
        coef_sel = sel;
        for (int k = 0; k <= N + 2; k++) begin
            tick;
            if (k == 0) begin
                start = 1'b0;
                base  = 16'($urandom);
            end
            ea = b + 16'(((k < N - 1) ? k : N - 1) * STR);
            n_cmp++;
            if (mem_addr !== ea) begin
                n_err++;
                $display("FAIL load mem_addr E%0d: got %h expected %h", k, mem_addr, ea);
            end
            n_cmp++;
            if (busy !== (k <= N)) begin
                n_err++;
                $display("FAIL load busy E%0d: got %b expected %b", k, busy, (k <= N));
            end
            n_cmp++;
            if (done !== (k == N + 1)) begin
                n_err++;
                $display("FAIL load done E%0d: got %b expected %b", k, done, (k == N + 1));
            end
            n_cmp++;
            if (valid !== (k >= N + 1)) begin
                n_err++;
                $display("FAIL load valid E%0d: got %b expected %b", k, valid, (k >= N + 1));
            end
            if (sel >= 4'(N)) begin
                n_cmp++;
                if (coef !== 16'h0000) begin
                    n_err++;
                    $display("FAIL oor coef sel=%0d E%0d: got %h expected 0000", sel, k, coef);
                end
            end
            sel      = 4'($urandom_range(0, 15));
            coef_sel = sel;
            if (lockout && k == 2) begin
                start = 1'b1;
                base  = 16'h0040;
            end
            if (lockout && k == 3) start = 1'b0;
            if (chain && k == N + 1) begin
                start = 1'b1;
                base  = nb;
                break;
            end
        end
        if (!chain) check_bank(b, "bank");
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        base  = 16'h1234;
        tick;
        tick;
        n_cmp++;
        if (mem_addr !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got addr=%h busy=%b done=%b valid=%b expected 0000/0/0/0",
                     mem_addr, busy, done, valid);
        end
        for (int s = 0; s < 16; s++) begin
            coef_sel = 4'(s);
            #1;
            n_cmp++;
            if (coef !== 16'h0000) begin
                n_err++;
                $display("FAIL reset coef[%0d]: got %h expected 0000", s, coef);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_full_load;
        run_load(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick;
    endtask

    task automatic test_busy_lockout;
        run_load(16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick;
    endtask

    task automatic test_reset_mid;
        base  = 16'h0100;
        start = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick;
            start = 1'b0;
        end
        reset = 1'b1;
        tick;
        n_cmp++;
        if (mem_addr !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0
            || coef_all !== '0) begin
            n_err++;
            $display("FAIL midreset: got addr=%h busy=%b done=%b valid=%b all=%h expected zeros",
                     mem_addr, busy, done, valid, coef_all);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset idle c%0d: got done=%b busy=%b valid=%b expected 0/0/0",
                         c, done, busy, valid);
            end
        end
    endtask

    task automatic test_wrap;
        run_load(16'hFFF8, 1'b0, 1'b0, 1'b0, 16'h0000);
        coef_sel = 4'd2;
        #1;
        n_cmp++;
        if (coef !== 16'h0100) begin
            n_err++;
            $display("FAIL wrap bank[2]: got %h expected 0100", coef);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        run_load(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0024);
        run_load(16'h0024, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick;
    endtask

    task automatic test_random;
        logic [SIZE-1:0] b;
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom) & 16'hFFFC;
            run_load(b, 1'b0, 1'b0, 1'b0, 16'h0000);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick;
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        base     = 16'h0000;
        coef_sel = 4'h0;
        test_reset;
        test_full_load;
        test_busy_lockout;
        test_reset_mid;
        test_wrap;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
